// File: rtl/pbvi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pbvi_pkg
//  Description : Shared types and constants for the PBVI datapath: action
//                encodings, policy-engine FSM states, value-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pbvi_pkg;

    localparam logic [1:0] ACT_NONE = 2'b00;
    localparam logic [1:0] ACT_A1   = 2'b01;
    localparam logic [1:0] ACT_A2   = 2'b10;
    localparam logic [1:0] ACT_A3   = 2'b11;

    // Number of belief states handled by the datapath.
    localparam int num_s = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // A two-term dot product of w-bit operands needs 2w bits per product
    // plus one carry bit for the sum.
    function automatic int value_width(input int width);
        return 2 * width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pbvi_dot2.sv
`default_nettype none
// ============================================================================
//  Module      : pbvi_dot2
//  Description : Combinational two-term unsigned multiply-accumulate,
//                value = b0*s0 + b1*s1 at full precision.
//  Revision    : 1.0 - initial release
// ============================================================================
module pbvi_dot2
    import pbvi_pkg::*;
#(
    parameter int w = 16
) (
    input  logic [w-1:0]              i_b0,
    input  logic [w-1:0]              i_b1,
    input  logic [w-1:0]              i_s0,
    input  logic [w-1:0]              i_s1,
    output logic [value_width(w)-1:0] o_value
);

    localparam int c_vw = value_width(w);

    logic [c_vw-1:0] w_p0;
    logic [c_vw-1:0] w_p1;

    // Operands widened before multiplying so neither product nor sum truncates.
    always_comb begin
        w_p0    = c_vw'(i_b0) * c_vw'(i_s0);
        w_p1    = c_vw'(i_b1) * c_vw'(i_s1);
        o_value = w_p0 + w_p1;
    end

endmodule
`default_nettype wire

// File: rtl/pbvi_policy_exec.sv
`default_nettype none
// ============================================================================
//  Module      : pbvi_policy_exec
//  Description : Policy-execution engine. Holds the alpha-vector table and,
//                per belief query, scans every entry (one per cycle) to
//                return the maximising action, value and index.
//  Revision    : 1.0 - initial release
// ============================================================================
module pbvi_policy_exec
    import pbvi_pkg::*;
#(
    parameter int num_b = 16,
    parameter int w     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    output logic                       wr_ready,
    input  logic [$clog2(num_b)-1:0]   wr_idx,
    input  logic [w-1:0]               wr_s0,
    input  logic [w-1:0]               wr_s1,
    input  logic [1:0]                 wr_act,
    input  logic                       clr,
    input  logic                       q_valid,
    output logic                       q_ready,
    input  logic [w-1:0]               q_b0,
    input  logic [w-1:0]               q_b1,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [1:0]                 res_action,
    output logic [value_width(w)-1:0]  res_value,
    output logic [$clog2(num_b)-1:0]   res_idx
);

    localparam int c_iw = $clog2(num_b);
    localparam int c_vw = value_width(w);
    localparam logic [c_iw-1:0] c_last = c_iw'(num_b - 1);

    // Alpha-vector table, register based so clr can empty it in one cycle.
    logic [w-1:0]     tab_s0_q  [num_b];
    logic [w-1:0]     tab_s0_d  [num_b];
    logic [w-1:0]     tab_s1_q  [num_b];
    logic [w-1:0]     tab_s1_d  [num_b];
    logic [1:0]       tab_act_q [num_b];
    logic [1:0]       tab_act_d [num_b];
    logic [num_b-1:0] tab_vld_q, tab_vld_d;

    state_t           state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [w-1:0]     b0_q, b0_d, b1_q, b1_d;
    logic [c_iw-1:0]  ptr_q, ptr_d;
    logic [c_vw-1:0]  best_val_q, best_val_d;
    logic [1:0]       best_act_q, best_act_d;
    logic [c_iw-1:0]  best_idx_q, best_idx_d;
    logic             res_valid_q, res_valid_d;
    logic [1:0]       res_act_q, res_act_d;
    logic [c_vw-1:0]  res_val_q, res_val_d;
    logic [c_iw-1:0]  res_idx_q, res_idx_d;

    logic [c_vw-1:0]  w_value;
    logic             w_win;

    assign wr_ready   = rdy_q;
    assign q_ready    = rdy_q;
    assign res_valid  = res_valid_q;
    assign res_action = res_act_q;
    assign res_value  = res_val_q;
    assign res_idx    = res_idx_q;

    pbvi_dot2 #(.w(w)) u_dot2 (
        .i_b0    (b0_q),
        .i_b1    (b1_q),
        .i_s0    (tab_s0_q[ptr_q]),
        .i_s1    (tab_s1_q[ptr_q]),
        .o_value (w_value)
    );

    // An empty best always loses to a valid entry; otherwise strictly greater
    // is required, so ties keep the lowest index.
    assign w_win = tab_vld_q[ptr_q] && ((w_value > best_val_q) || (best_act_q == ACT_NONE));

    // Table update: writes only while idle, clear overrides any write.
    always_comb begin
        tab_s0_d  = tab_s0_q;
        tab_s1_d  = tab_s1_q;
        tab_act_d = tab_act_q;
        tab_vld_d = tab_vld_q;
        if (wr_en && rdy_q) begin
            tab_s0_d[wr_idx]  = wr_s0;
            tab_s1_d[wr_idx]  = wr_s1;
            tab_act_d[wr_idx] = wr_act;
            tab_vld_d[wr_idx] = 1'b1;
        end
        if (clr) begin
            tab_vld_d = '0;
        end
    end

    // Table payload needs no reset; only the valid bits define content.
    always_ff @(posedge clk) begin
        tab_s0_q  <= tab_s0_d;
        tab_s1_q  <= tab_s1_d;
        tab_act_q <= tab_act_d;
    end

    // Scan FSM next state, best tracking and result capture.
    always_comb begin
        state_d     = state_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        ptr_d       = ptr_q;
        best_val_d  = best_val_q;
        best_act_d  = best_act_q;
        best_idx_d  = best_idx_q;
        res_valid_d = res_valid_q;
        res_act_d   = res_act_q;
        res_val_d   = res_val_q;
        res_idx_d   = res_idx_q;
        case (state_q)
            IDLE: begin
                if (q_valid) begin
                    b0_d       = q_b0;
                    b1_d       = q_b1;
                    best_val_d = '0;
                    best_act_d = ACT_NONE;
                    best_idx_d = '0;
                    ptr_d      = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (w_win) begin
                    best_val_d = w_value;
                    best_act_d = tab_act_q[ptr_q];
                    best_idx_d = ptr_q;
                end
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == c_last) begin
                    // Capture includes the last entry's evaluation.
                    state_d     = DONE;
                    res_valid_d = 1'b1;
                    res_act_d   = best_act_d;
                    res_val_d   = best_val_d;
                    res_idx_d   = best_idx_d;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
        rdy_d = (state_d == IDLE);
    end

    // Control and result registers; reset aborts any scan and empties the table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b1;
            tab_vld_q   <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            ptr_q       <= '0;
            best_val_q  <= '0;
            best_act_q  <= ACT_NONE;
            best_idx_q  <= '0;
            res_valid_q <= 1'b0;
            res_act_q   <= ACT_NONE;
            res_val_q   <= '0;
            res_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            tab_vld_q   <= tab_vld_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            ptr_q       <= ptr_d;
            best_val_q  <= best_val_d;
            best_act_q  <= best_act_d;
            best_idx_q  <= best_idx_d;
            res_valid_q <= res_valid_d;
            res_act_q   <= res_act_d;
            res_val_q   <= res_val_d;
            res_idx_q   <= res_idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pbvi_policy_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pbvi_policy_exec
//  Description : Self-checking bench for pbvi_policy_exec: vector table of
//                writes/clears/queries plus hand-written handshake, dropped
//                write, simultaneous write+query and async-reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pbvi_policy_exec;

    localparam int c_nb = 16;
    localparam int c_w  = 16;
    localparam int c_vw = 2 * c_w + 1;

    localparam int OP_WR  = 0;
    localparam int OP_CLR = 1;
    localparam int OP_Q   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_en = 1'b0;
    logic            wr_ready;
    logic [3:0]      wr_idx = '0;
    logic [c_w-1:0]  wr_s0 = '0;
    logic [c_w-1:0]  wr_s1 = '0;
    logic [1:0]      wr_act = '0;
    logic            clr = 1'b0;
    logic            q_valid = 1'b0;
    logic            q_ready;
    logic [c_w-1:0]  q_b0 = '0;
    logic [c_w-1:0]  q_b1 = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [1:0]      res_action;
    logic [c_vw-1:0] res_value;
    logic [3:0]      res_idx;

    pbvi_policy_exec #(.num_b(c_nb), .w(c_w)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_idx     (wr_idx),
        .wr_s0      (wr_s0),
        .wr_s1      (wr_s1),
        .wr_act     (wr_act),
        .clr        (clr),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .q_b0       (q_b0),
        .q_b1       (q_b1),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_action (res_action),
        .res_value  (res_value),
        .res_idx    (res_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              op;
        logic [3:0]      idx;
        logic [c_w-1:0]  x0;
        logic [c_w-1:0]  x1;
        logic [1:0]      act;
        logic [1:0]      e_act;
        logic [c_vw-1:0] e_val;
        logic [3:0]      e_idx;
    } vec_t;

    typedef struct {
        logic [1:0]      act;
        logic [c_vw-1:0] val;
        logic [3:0]      idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   acc_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_write(input logic [3:0] idx, input logic [c_w-1:0] s0,
                            input logic [c_w-1:0] s1, input logic [1:0] act);
        wr_en = 1'b1; wr_idx = idx; wr_s0 = s0; wr_s1 = s1; wr_act = act;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic start_query(input logic [c_w-1:0] b0, input logic [c_w-1:0] b1,
                               input logic [1:0] ea, input logic [c_vw-1:0] ev,
                               input logic [3:0] ei);
        exp_t e;
        check("q_ready_before_query", 64'(q_ready), 64'd1);
        q_valid = 1'b1; q_b0 = b0; q_b1 = b1;
        e.act = ea; e.val = ev; e.idx = ei;
        sb.push_back(e);
        @(negedge clk);
        q_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_result(input string name, input int hold);
        exp_t e;
        bit   seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty when result arrived", name);
            return;
        end
        e = sb.pop_front();
        check({name, "_seen"}, 64'(seen), 64'd1);
        if (!seen) return;
        check({name, "_latency"}, 64'(cyc - acc_cyc), 64'(c_nb));
        check({name, "_action"}, 64'(res_action), 64'(e.act));
        check({name, "_value"},  64'(res_value),  64'(e.val));
        check({name, "_idx"},    64'(res_idx),    64'(e.idx));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_valid"},  64'(res_valid),  64'd1);
            check({name, "_hold_action"}, 64'(res_action), 64'(e.act));
            check({name, "_hold_value"},  64'(res_value),  64'(e.val));
            check({name, "_hold_idx"},    64'(res_idx),    64'(e.idx));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({name, "_valid_drop"}, 64'(res_valid), 64'd0);
        check({name, "_q_ready_back"}, 64'(q_ready), 64'd1);
    endtask

    task automatic push_q(input logic [c_w-1:0] b0, input logic [c_w-1:0] b1,
                          input logic [1:0] ea, input logic [c_vw-1:0] ev, input logic [3:0] ei);
        vecs.push_back('{OP_Q, 4'd0, b0, b1, 2'd0, ea, ev, ei});
    endtask

    task automatic push_w(input logic [3:0] idx, input logic [c_w-1:0] s0,
                          input logic [c_w-1:0] s1, input logic [1:0] act);
        vecs.push_back('{OP_WR, idx, s0, s1, act, 2'd0, '0, 4'd0});
    endtask

    task automatic push_c();
        vecs.push_back('{OP_CLR, 4'd0, '0, '0, 2'd0, 2'd0, '0, 4'd0});
    endtask

    initial begin
        bit rv_seen;

        // Empty table
        push_q(16'd5, 16'd7, 2'b00, '0, 4'd0);
        // Single best
        push_w(4'd0, 16'd1, 16'd1, 2'b01);
        push_w(4'd1, 16'd2, 16'd2, 2'b10);
        push_w(4'd2, 16'd3, 16'd3, 2'b11);
        push_q(16'd4, 16'd6, 2'b11, 33'd30, 4'd2);
        // Tie keeps lowest index; other beliefs move the winner
        push_c();
        push_w(4'd3, 16'd2, 16'd0, 2'b01);
        push_w(4'd9, 16'd0, 16'd2, 2'b10);
        push_q(16'd1, 16'd1, 2'b01, 33'd2, 4'd3);
        push_q(16'd3, 16'd1, 2'b01, 33'd6, 4'd3);
        push_q(16'd1, 16'd5, 2'b10, 33'd10, 4'd9);
        // Zero-scoring valid entries beat an empty best; ties stay at lowest
        push_c();
        push_w(4'd7, 16'd0, 16'd0, 2'b11);
        push_w(4'd12, 16'd0, 16'd0, 2'b10);
        push_q(16'd5, 16'd5, 2'b11, 33'd0, 4'd7);
        // Overwrite of an existing index
        push_w(4'd7, 16'd1, 16'd0, 2'b10);
        push_q(16'd2, 16'd3, 2'b10, 33'd2, 4'd7);
        // Last table entry participates
        push_w(4'd15, 16'd9, 16'd9, 2'b01);
        push_q(16'd1, 16'd1, 2'b01, 33'd18, 4'd15);
        // Width extreme, then clear
        push_c();
        push_w(4'd0, 16'hFFFF, 16'hFFFF, 2'b10);
        push_w(4'd15, 16'hFFFF, 16'hFFFF, 2'b10);
        push_q(16'hFFFF, 16'hFFFF, 2'b10, 33'h1_FFFC_0002, 4'd0);
        push_c();
        push_q(16'd1, 16'd1, 2'b00, '0, 4'd0);

        // Reset state
        #12;
        check("reset_res_valid", 64'(res_valid), 64'd0);
        check("reset_res_action", 64'(res_action), 64'd0);
        check("reset_res_value", 64'(res_value), 64'd0);
        check("reset_res_idx", 64'(res_idx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_q_ready", 64'(q_ready), 64'd1);
        check("reset_wr_ready", 64'(wr_ready), 64'd1);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_WR:  do_write(vecs[i].idx, vecs[i].x0, vecs[i].x1, vecs[i].act);
                OP_CLR: do_clr();
                default: begin
                    start_query(vecs[i].x0, vecs[i].x1, vecs[i].e_act, vecs[i].e_val, vecs[i].e_idx);
                    wait_result($sformatf("vec%0d", i), 0);
                end
            endcase
        end

        // Result held while res_ready stays low
        do_clr();
        do_write(4'd2, 16'd3, 16'd4, 2'b01);
        start_query(16'd1, 16'd1, 2'b01, 33'd7, 4'd2);
        wait_result("hold5", 5);

        // Write during scan is dropped
        start_query(16'd1, 16'd1, 2'b01, 33'd7, 4'd2);
        repeat (3) @(negedge clk);
        check("scan_wr_ready_low", 64'(wr_ready), 64'd0);
        check("scan_q_ready_low", 64'(q_ready), 64'd0);
        do_write(4'd6, 16'd100, 16'd100, 2'b11);
        wait_result("scan_drop", 0);
        start_query(16'd1, 16'd1, 2'b01, 33'd7, 4'd2);
        wait_result("after_drop", 0);

        // Simultaneous idle write and query: scan sees the new entry
        wr_en = 1'b1; wr_idx = 4'd5; wr_s0 = 16'd9; wr_s1 = 16'd9; wr_act = 2'b10;
        start_query(16'd1, 16'd1, 2'b10, 33'd18, 4'd5);
        wr_en = 1'b0;
        wait_result("simul_wr_q", 0);

        // Async reset mid-scan
        start_query(16'd1, 16'd1, 2'b10, 33'd18, 4'd5);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midscan_rst_res_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("post_rst_q_ready", 64'(q_ready), 64'd1);
        check("post_rst_wr_ready", 64'(wr_ready), 64'd1);
        rv_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid) rv_seen = 1;
        end
        check("aborted_scan_no_result", 64'(rv_seen), 64'd0);
        start_query(16'd1, 16'd1, 2'b00, '0, 4'd0);
        wait_result("post_rst_empty", 0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
